// File: rtl/otter_uart_pkg.sv
// Shared definitions for the OTTER UART: transmitter FSM states and baud divisor helper.
package otter_uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  // Clocks per bit, rounded to nearest; also used by the receiver.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/otter_uart_tx_if.sv
// MMIO write/status bundle between the OTTER bus and the UART transmitter.
interface otter_uart_tx_if;

  logic                              wr_en;
  logic [otter_uart_pkg::DATA_W-1:0] wr_data;
  logic                              full;
  logic                              empty;
  logic                              busy;
  logic                              overflow;
  logic                              tx;

  modport master (output wr_en, wr_data, input full, empty, busy, overflow, tx);
  modport slave  (input wr_en, wr_data, output full, empty, busy, overflow, tx);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-derived registered full/empty; a pop frees room for a same-cycle push.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty,
  output logic             empty_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_pop    = pop && !empty;
    do_push   = push && (!full || do_pop);
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  assign empty_nxt_c = (count_nxt == '0);
  assign rd_data_c   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/otter_uart_tx.sv
// 8N1 UART transmitter: buffers MMIO byte writes in a FIFO and serialises them LSB first.
module otter_uart_tx
  import otter_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  otter_uart_tx_if.slave  bus
);

  localparam int unsigned      DIV      = calc_div(CLK_HZ, BAUD);
  localparam int unsigned      CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  uart_tx_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] shift;
  logic              tx_q;
  logic              busy_q;
  logic              overflow_q;

  logic              bit_end_c;
  logic              pop_c;
  logic [DATA_W-1:0] head_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_empty_nxt_c;

  assign bit_end_c = (cnt == CNT_LAST);
  // Pop from idle, or on the last stop cycle to chain frames without a gap.
  assign pop_c     = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end_c));

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (bus.wr_en),
    .wr_data     (bus.wr_data),
    .pop         (pop_c),
    .rd_data_c   (head_c),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      busy_q     <= 1'b1;
      overflow_q <= overflow_q | (bus.wr_en & fifo_full & ~pop_c);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!fifo_empty) begin
            shift <= head_c;
            tx_q  <= 1'b0;
            state <= START;
          end else begin
            tx_q   <= 1'b1;
            busy_q <= !fifo_empty_nxt_c;
          end
        end
        START: begin
          if (bit_end_c) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx_q    <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx_q    <= shift[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            cnt <= '0;
            if (!fifo_empty) begin
              shift <= head_c;
              tx_q  <= 1'b0;
              state <= START;
            end else begin
              state  <= IDLE;
              busy_q <= !fifo_empty_nxt_c;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = overflow_q;
  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;

endmodule
